// File: rtl/sprite_commit_sched_pkg.sv
// Shared types and widths for the sprite register commit scheduler.
// Holds the FSM state encoding and the packed FIFO entry layout.
package sprite_commit_sched_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int ENTRY_W   = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } upd_entry_t;

endpackage

// File: rtl/sprite_upd_fifo.sv
// Synchronous FIFO of pending sprite register updates.
// Pushes when full and pops when empty are ignored; head is the oldest entry.
module sprite_upd_fifo
  import sprite_commit_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  upd_entry_t       din,
  input  logic             pop,
  output upd_entry_t       head,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (level != FULL_LVL);
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; only entries between the pointers are ever visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sprite_commit_sched.sv
// Collects host and motion-engine sprite register updates and applies a
// snapshot of them, one per cycle, at the start of each vertical blank.
module sprite_commit_sched
  import sprite_commit_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [DATA_W-1:0] upd_data,
  output logic              commit_done,
  output logic [LVL_W-1:0]  level,
  output logic              busy
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  sched_state_e     state;
  sched_state_e     state_nxt;
  logic [LVL_W-1:0] snap_cnt;
  logic [LVL_W-1:0] snap_nxt;
  logic             vblank_q;
  logic             vb_rise;
  logic             last_b;
  logic             space;
  logic             a_grant;
  logic             b_grant;
  logic             push;
  logic             pop;
  logic             drain_now;
  logic             done_now;
  upd_entry_t       push_entry;
  upd_entry_t       head;

  assign vb_rise = vblank && !vblank_q;
  assign space   = (level != FULL_LVL);

  // Round-robin only matters under contention; last_b=1 after reset favours A.
  assign a_grant = rst_n && space && a_valid && (!b_valid || last_b);
  assign b_grant = rst_n && space && b_valid && (!a_valid || !last_b);
  assign a_ready = a_grant;
  assign b_ready = b_grant;
  assign push    = a_grant || b_grant;

  always_comb begin
    push_entry = '0;
    if (a_grant) begin
      push_entry.addr = a_addr;
      push_entry.data = a_data;
    end else if (b_grant) begin
      push_entry.addr = b_addr;
      push_entry.data = b_data;
    end
  end

  sprite_upd_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      snap_cnt <= '0;
      vblank_q <= 1'b0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nxt;
      snap_cnt <= snap_nxt;
      vblank_q <= vblank;
      if (push) last_b <= b_grant;
    end
  end

  // A drain interrupted by the end of blanking goes back to ARMED and keeps
  // the rest of the snapshot queued in order for the next rising edge.
  always_comb begin
    state_nxt = state;
    snap_nxt  = snap_cnt;
    drain_now = 1'b0;
    done_now  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (level != '0) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (vb_rise) begin
          state_nxt = ST_DRAIN;
          snap_nxt  = level;
        end
      end
      ST_DRAIN: begin
        if (snap_cnt == '0) begin
          state_nxt = ST_DONE;
        end else if (!vblank) begin
          state_nxt = ST_ARMED;
        end else begin
          drain_now = 1'b1;
          snap_nxt  = snap_cnt - 1'b1;
          if (snap_cnt == LVL_W'(1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_now  = 1'b1;
        state_nxt = (level != '0) ? ST_ARMED : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pop         = drain_now;
  assign upd_valid   = rst_n && drain_now;
  assign upd_addr    = upd_valid ? head.addr : '0;
  assign upd_data    = upd_valid ? head.data : '0;
  assign commit_done = rst_n && done_now;
  assign busy        = rst_n && (state != ST_IDLE);

endmodule

// File: tb/tb_sprite_commit_sched.sv
// Randomized bench for sprite_commit_sched against a queue-based model of the
// arbitration, snapshot and drain rules, plus a few directed scenarios.
module tb_sprite_commit_sched;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vblank;
  logic             a_valid;
  logic [5:0]       a_addr;
  logic [15:0]      a_data;
  logic             a_ready;
  logic             b_valid;
  logic [5:0]       b_addr;
  logic [15:0]      b_data;
  logic             b_ready;
  logic             upd_valid;
  logic [5:0]       upd_addr;
  logic [15:0]      upd_data;
  logic             commit_done;
  logic [LVL_W-1:0] level;
  logic             busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: queue of pending updates, phase 0 idle / 1 armed / 2 draining / 3 done
  ent_t m_q[$];
  int   m_phase;
  int   m_snap;
  bit   m_last_b;
  bit   m_vb_prev;

  always #5 clk = ~clk;

  sprite_commit_sched #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vblank      (vblank),
    .a_valid     (a_valid),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .upd_valid   (upd_valid),
    .upd_addr    (upd_addr),
    .upd_data    (upd_data),
    .commit_done (commit_done),
    .level       (level),
    .busy        (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_phase   = 0;
    m_snap    = 0;
    m_last_b  = 1'b1;
    m_vb_prev = 1'b0;
  endfunction

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input logic r, input logic vb,
                               input logic av, input logic [5:0] aa, input logic [15:0] ad,
                               input logic bv, input logic [5:0] ba, input logic [15:0] bd);
    bit   e_ar, e_br, e_upd, e_done, e_busy, rise;
    int   lvl;
    ent_t hd;
    ent_t nw;
    @(posedge clk);
    #1;
    rst_n = r; vblank = vb;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(negedge clk);
    lvl    = m_q.size();
    e_ar   = r && (lvl < DEPTH) && av && (!bv || m_last_b);
    e_br   = r && (lvl < DEPTH) && bv && (!av || !m_last_b);
    e_upd  = r && (m_phase == 2) && vb && (m_snap > 0);
    e_done = r && (m_phase == 3);
    e_busy = r && (m_phase != 0);
    hd.addr = '0; hd.data = '0;
    if (e_upd) hd = m_q[0];
    checkOutput("a_ready", 32'(a_ready), 32'(e_ar));
    checkOutput("b_ready", 32'(b_ready), 32'(e_br));
    checkOutput("upd_valid", 32'(upd_valid), 32'(e_upd));
    checkOutput("upd_addr", 32'(upd_addr), 32'(hd.addr));
    checkOutput("upd_data", 32'(upd_data), 32'(hd.data));
    checkOutput("commit_done", 32'(commit_done), 32'(e_done));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("level", 32'(level), 32'(lvl));
    if (!r) begin
      model_reset();
    end else begin
      rise = vb && !m_vb_prev;
      case (m_phase)
        0: if (lvl > 0) m_phase = 1;
        1: if (rise) begin m_phase = 2; m_snap = lvl; end
        2: begin
          if (m_snap == 0) m_phase = 3;
          else if (!vb) m_phase = 1;
          else begin
            m_snap--;
            if (m_snap == 0) m_phase = 3;
          end
        end
        default: m_phase = (lvl > 0) ? 1 : 0;
      endcase
      if (e_upd) void'(m_q.pop_front());
      if (e_ar) begin nw.addr = aa; nw.data = ad; m_q.push_back(nw); m_last_b = 1'b0; end
      if (e_br) begin nw.addr = ba; nw.data = bd; m_q.push_back(nw); m_last_b = 1'b1; end
      m_vb_prev = vb;
    end
  endtask

  task automatic idle_cycles(input int n, input logic vb);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, vb, 1'b0, 6'h0, 16'h0, 1'b0, 6'h0, 16'h0);
  endtask

  task automatic reset_dut();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, 16'h0, 1'b0, 6'h0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h3, 16'h1, 1'b1, 6'h5, 16'h2);
  endtask

  initial begin
    int vb_left;
    logic vb_cur;
    model_reset();
    rst_n = 1'b0; vblank = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    reset_dut();

    // Two host pushes, then one vblank drains them in order
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h04, 16'h1234, 1'b0, 6'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h06, 16'hFFFF, 1'b0, 6'h0, 16'h0);
    idle_cycles(3, 1'b0);
    idle_cycles(5, 1'b1);
    idle_cycles(2, 1'b0);

    // Contention fills the FIFO alternating A,B until both stall
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 6'(i), 16'(16'hA000 + i), 1'b1, 6'(i + 32), 16'(16'hB000 + i));

    // Interrupted drain: one pop, vblank falls, then the rest next blank
    idle_cycles(1, 1'b1);
    idle_cycles(1, 1'b1);
    idle_cycles(2, 1'b0);
    idle_cycles(6, 1'b1);
    idle_cycles(2, 1'b0);

    // Push during drain lands in the following blanking interval
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 6'(i + 8), 16'(16'h0C00 + i), 1'b0, 6'h0, 16'h0);
    idle_cycles(2, 1'b0);
    idle_cycles(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h0, 16'h0, 1'b1, 6'h1A, 16'h0505);
    idle_cycles(4, 1'b1);
    idle_cycles(2, 1'b0);
    idle_cycles(4, 1'b1);
    idle_cycles(2, 1'b0);

    // Reset in the middle of a drain discards everything
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h11, 16'h1111, 1'b0, 6'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h12, 16'h2222, 1'b0, 6'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h13, 16'h3333, 1'b0, 6'h0, 16'h0);
    idle_cycles(2, 1'b0);
    idle_cycles(1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 16'h0, 1'b0, 6'h0, 16'h0);
    idle_cycles(2, 1'b0);
    idle_cycles(3, 1'b1);
    idle_cycles(1, 1'b0);

    // Random traffic with random blanking lengths and occasional resets
    vb_cur  = 1'b0;
    vb_left = 4;
    for (int c = 0; c < 4000; c++) begin
      if (vb_left == 0) begin
        vb_cur  = ~vb_cur;
        vb_left = vb_cur ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 14));
      end
      vb_left--;
      applyStimulus(($urandom_range(0, 399) != 0), vb_cur,
                    ($urandom_range(0, 1) == 1), 6'($urandom), 16'($urandom),
                    ($urandom_range(0, 2) == 0), 6'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
